// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/[parity]/stop deserializer sampling din on bit_en strobes (parity via SERIAL_FRAME_RX_PARITY_EN).
// Latency: dout_valid/frame_err one cycle after the stop strobe; DATA_W+1 strobes from start (+1 with parity).
// Backpressure: none; bit_en=0 freezes the frame, result pulses always last exactly one cycle.
module serial_frame_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef SERIAL_FRAME_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              parity_ok;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic par;
  // even parity: data bits plus parity bit must XOR to zero
  assign parity_ok = ~^{shreg, par};
`else
  assign parity_ok = 1'b1;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!din) begin
              state <= DATA;
              cnt   <= '0;
              shreg <= '0;
            end
          end
          DATA: begin
            for (int i = 0; i < DATA_W; i++) begin
              if (cnt == CW'(i)) shreg[i] <= din;
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef SERIAL_FRAME_RX_PARITY_EN
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
`endif
          STOP: begin
            if (din) begin
              if (parity_ok) begin
                dout       <= shreg;
                dout_valid <= 1'b1;
              end else begin
                frame_err  <= 1'b1;
              end
              state <= IDLE;
            end else begin
              // held-low line: flag once, then wait out the break
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
          BREAK: begin
            if (din) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: reset, good/bad frames, sparse strobes, mid-frame reset, back-to-back.
module tb_serial_frame_rx;
  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       din;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int nv = 0;
  int ne = 0;
  int nboth = 0;

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid) nv++;
      if (frame_err) ne++;
      if (dout_valid && frame_err) nboth++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    din    = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_body(input logic [7:0] d, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < 8; i++) strobe(d[i], gap);
  endtask

  task automatic send_stop(input logic s);
    din    = s;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    din    = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic s, input int gap);
    send_body(d, gap);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    strobe(^d, gap);
`endif
    send_stop(s);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; bit_en = 1'b0; din = 1'b1;
    // reset with din toggling
    din = 1'b0; tick();
    din = 1'b1; tick();
    check("rst_dout", dout, 8'h00);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0; din = 1'b1; bit_en = 1'b1;
    repeat (3) tick();
    bit_en = 1'b0;
    check("idle_busy", busy, 1'b0);
    check("idle_valid", dout_valid, 1'b0);

    // good frame 8'h4A, strobe every cycle
    nv = 0; ne = 0;
    send_body(8'h4A, 0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    strobe(1'b1, 0);
`endif
    check("good_prestop_valid", dout_valid, 1'b0);
    check("good_prestop_busy", busy, 1'b1);
    send_stop(1'b1);
    check("good_valid", dout_valid, 1'b1);
    check("good_dout", dout, 8'h4A);
    check("good_busy", busy, 1'b0);
    tick();
    check("good_valid_clr", dout_valid, 1'b0);
    check("good_nv", nv, 1);
    check("good_ne", ne, 0);

    // stop error followed by a held-low line
    nv = 0; ne = 0;
    send_frame(8'hFF, 1'b0, 0);
    check("brk_err", frame_err, 1'b1);
    check("brk_valid", dout_valid, 1'b0);
    check("brk_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) strobe(1'b0, 0);
    check("brk_err_clr", frame_err, 1'b0);
    check("brk_busy_low", busy, 1'b1);
    strobe(1'b1, 0);
    check("brk_busy_idle", busy, 1'b0);
    tick();
    check("brk_ne", ne, 1);
    check("brk_nv", nv, 0);
    check("brk_dout", dout, 8'h4A);

    // sparse strobes, every 4th cycle
    nv = 0; ne = 0;
    send_body(8'hA5, 3);
    check("sparse_busy_frozen", busy, 1'b1);
    check("sparse_nv_pre", nv, 0);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    strobe(1'b0, 3);
`endif
    send_stop(1'b1);
    check("sparse_valid", dout_valid, 1'b1);
    check("sparse_dout", dout, 8'hA5);
    tick();
    check("sparse_valid_clr", dout_valid, 1'b0);
    repeat (3) tick();
    check("sparse_nv", nv, 1);

    // reset in the middle of 8'h3C
    nv = 0; ne = 0;
    strobe(1'b0, 0);
    strobe(1'b0, 0); strobe(1'b0, 0); strobe(1'b1, 0); strobe(1'b1, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) tick();
    check("mid_rst_nv", nv, 0);
    check("mid_rst_ne", ne, 0);
    send_frame(8'h81, 1'b1, 0);
    check("mid_rst_dout", dout, 8'h81);
    tick();
    check("mid_rst_nv_after", nv, 1);

    // back-to-back frames, start bit right after stop strobe
    nv = 0; ne = 0;
    send_frame(8'h12, 1'b1, 0);
    check("b2b_dout0", dout, 8'h12);
    send_frame(8'h34, 1'b1, 0);
    check("b2b_dout1", dout, 8'h34);
    tick();
    check("b2b_nv", nv, 2);
    check("b2b_ne", ne, 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // 8'h07 has three ones: parity bit 1 is even, 0 is odd
    nv = 0; ne = 0;
    send_body(8'h07, 0);
    strobe(1'b1, 0);
    send_stop(1'b1);
    check("par_good_valid", dout_valid, 1'b1);
    check("par_good_dout", dout, 8'h07);
    send_body(8'h07, 0);
    strobe(1'b0, 0);
    send_stop(1'b1);
    check("par_bad_err", frame_err, 1'b1);
    check("par_bad_valid", dout_valid, 1'b0);
    check("par_bad_dout", dout, 8'h07);
    check("par_bad_busy", busy, 1'b0);
    tick();
    check("par_nv", nv, 1);
    check("par_ne", ne, 1);
`endif

    check("never_both", nboth, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
